// File: rtl/mtr_drv_if.sv
// Bus between the balance-control math and the dual H-bridge PWM driver:
// speed commands and enable in, four gate drives and period marker out.
interface mtr_drv_if;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        en;
    logic        lft_fwd;
    logic        lft_rev;
    logic        rght_fwd;
    logic        rght_rev;
    logic        prd_start;

    modport master (
        output lft_spd, rght_spd, en,
        input  lft_fwd, lft_rev, rght_fwd, rght_rev, prd_start
    );

    modport slave (
        input  lft_spd, rght_spd, en,
        output lft_fwd, lft_rev, rght_fwd, rght_rev, prd_start
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM generator: 2048-clock edge-aligned period, speed sampled
// once per period, dead interval on the first period after a wheel reverses.
module mtr_drv #(
    parameter int DEAD = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mtr_drv_if.slave  bus
);

    localparam logic [10:0] DEAD_C = 11'(DEAD);

    logic [10:0] cnt;
    logic        wrap;

    logic [10:0] lft_duty;
    logic        lft_dir;
    logic        lft_chg;
    logic        lft_dir_nxt;
    logic        lft_act;

    logic [10:0] rght_duty;
    logic        rght_dir;
    logic        rght_chg;
    logic        rght_dir_nxt;
    logic        rght_act;

    logic        lft_fwd_q;
    logic        lft_rev_q;
    logic        rght_fwd_q;
    logic        rght_rev_q;
    logic        prd_start_q;

    // 12-bit negation, then clamp so -2048 saturates to full duty.
    function automatic logic [10:0] spd_mag(input logic [11:0] spd);
        logic [11:0] m;
        m = spd[11] ? (~spd + 12'd1) : spd;
        return m[11] ? 11'h7FF : m[10:0];
    endfunction

    assign wrap = (cnt == 11'h7FF);

    // A zero command keeps the previous direction so no dead interval is forced.
    assign lft_dir_nxt  = (bus.lft_spd  != 12'd0) ? bus.lft_spd[11]  : lft_dir;
    assign rght_dir_nxt = (bus.rght_spd != 12'd0) ? bus.rght_spd[11] : rght_dir;

    assign lft_act  = bus.en && (cnt < lft_duty)  && !(lft_chg  && (cnt < DEAD_C));
    assign rght_act = bus.en && (cnt < rght_duty) && !(rght_chg && (cnt < DEAD_C));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 11'd0;
            lft_duty  <= 11'd0;
            lft_dir   <= 1'b0;
            lft_chg   <= 1'b0;
            rght_duty <= 11'd0;
            rght_dir  <= 1'b0;
            rght_chg  <= 1'b0;
        end else begin
            cnt <= cnt + 11'd1;
            if (wrap) begin
                lft_duty  <= spd_mag(bus.lft_spd);
                lft_dir   <= lft_dir_nxt;
                lft_chg   <= (lft_dir_nxt != lft_dir);
                rght_duty <= spd_mag(bus.rght_spd);
                rght_dir  <= rght_dir_nxt;
                rght_chg  <= (rght_dir_nxt != rght_dir);
            end
        end
    end

    // Registered legs: the level for count k shows one clock after cnt == k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_fwd_q   <= 1'b0;
            lft_rev_q   <= 1'b0;
            rght_fwd_q  <= 1'b0;
            rght_rev_q  <= 1'b0;
            prd_start_q <= 1'b0;
        end else begin
            lft_fwd_q   <= lft_act  && !lft_dir;
            lft_rev_q   <= lft_act  &&  lft_dir;
            rght_fwd_q  <= rght_act && !rght_dir;
            rght_rev_q  <= rght_act &&  rght_dir;
            prd_start_q <= (cnt == 11'd0);
        end
    end

    assign bus.lft_fwd   = lft_fwd_q;
    assign bus.lft_rev   = lft_rev_q;
    assign bus.rght_fwd  = rght_fwd_q;
    assign bus.rght_rev  = rght_rev_q;
    assign bus.prd_start = prd_start_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: measures whole PWM periods leg by leg and
// compares pulse widths and start offsets against hand-computed values.
module tb_mtr_drv;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    int n_lf, n_lr, n_rf, n_rr;
    int f_lf, f_lr, f_rf, f_rr;
    int ovl, prd_n, last_rr, hi_after, wait_n;

    mtr_drv_if bus ();

    mtr_drv #(.DEAD(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Measures one full period starting at the next prd_start; optionally
    // changes speeds / enable after sampling the given window index.
    task automatic measure(input int chg_idx, input logic [11:0] nl, input logic [11:0] nr,
                           input int en_idx, input logic en_val);
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (bus.prd_start !== 1'b1 && wait_n < 2100);
        n_lf = 0; n_lr = 0; n_rf = 0; n_rr = 0;
        f_lf = -1; f_lr = -1; f_rf = -1; f_rr = -1;
        ovl = 0; prd_n = 0; last_rr = 0; hi_after = 0;
        if (bus.prd_start !== 1'b1) begin
            total++;
            $display("FAIL prd_wait: no prd_start after %0d cycles, expected one within 2048", wait_n);
            return;
        end
        for (int j = 0; j < 2048; j++) begin
            if (j > 0) @(negedge clk);
            if (bus.lft_fwd  === 1'b1) begin n_lf++; if (f_lf < 0) f_lf = j; end
            if (bus.lft_rev  === 1'b1) begin n_lr++; if (f_lr < 0) f_lr = j; end
            if (bus.rght_fwd === 1'b1) begin n_rf++; if (f_rf < 0) f_rf = j; end
            if (bus.rght_rev === 1'b1) begin n_rr++; if (f_rr < 0) f_rr = j; end
            if ((bus.lft_fwd === 1'b1 && bus.lft_rev === 1'b1) ||
                (bus.rght_fwd === 1'b1 && bus.rght_rev === 1'b1)) ovl++;
            if (bus.prd_start === 1'b1) prd_n++;
            if (j == 2047) last_rr = (bus.rght_rev === 1'b1) ? 1 : 0;
            if (en_idx >= 0 && j > en_idx &&
                (bus.lft_fwd !== 1'b0 || bus.lft_rev !== 1'b0 ||
                 bus.rght_fwd !== 1'b0 || bus.rght_rev !== 1'b0)) hi_after++;
            if (j == chg_idx) begin
                bus.lft_spd  = nl;
                bus.rght_spd = nr;
            end
            if (j == en_idx) bus.en = en_val;
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0;
        bus.lft_spd = 12'd0;
        bus.rght_spd = 12'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({bus.lft_fwd, bus.lft_rev, bus.rght_fwd, bus.rght_rev, bus.prd_start} !== 5'b0)
            $display("FAIL reset_outputs got %b exp 00000",
                     {bus.lft_fwd, bus.lft_rev, bus.rght_fwd, bus.rght_rev, bus.prd_start}); else passed++;
        rst_n = 1'b1;
        bus.en = 1'b1;
        bus.lft_spd = 12'd1000;
        bus.rght_spd = 12'h800;
        measure(-1, 12'd0, 12'd0, -1, 1'b1);
        total++; if (wait_n !== 1) $display("FAIL first_prd_delay got %0d exp 1", wait_n); else passed++;
        total++; if (prd_n !== 1) $display("FAIL prd_per_period got %0d exp 1", prd_n); else passed++;
        total++; if (n_lf + n_lr + n_rf + n_rr !== 0)
            $display("FAIL pre_load_quiet got %0d high cycles exp 0", n_lf + n_lr + n_rf + n_rr); else passed++;
    endtask

    task automatic test_forward_fullscale();
        // right side reverses out of reset direction, so first period is dead-gapped
        measure(-1, 12'd0, 12'd0, -1, 1'b1);
        total++; if (n_lf !== 1000) $display("FAIL fwd_width got %0d exp 1000", n_lf); else passed++;
        total++; if (f_lf !== 0) $display("FAIL fwd_start got %0d exp 0", f_lf); else passed++;
        total++; if (n_lr !== 0) $display("FAIL fwd_rev_leg got %0d exp 0", n_lr); else passed++;
        total++; if (n_rr !== 2015) $display("FAIL fs_first_width got %0d exp 2015", n_rr); else passed++;
        total++; if (f_rr !== 32) $display("FAIL fs_first_start got %0d exp 32", f_rr); else passed++;
        measure(10, 12'd500, 12'h800, -1, 1'b1);
        total++; if (n_lf !== 1000) $display("FAIL fwd_width2 got %0d exp 1000", n_lf); else passed++;
        total++; if (n_rr !== 2047) $display("FAIL fs_width got %0d exp 2047", n_rr); else passed++;
        total++; if (f_rr !== 0) $display("FAIL fs_start got %0d exp 0", f_rr); else passed++;
        total++; if (last_rr !== 0) $display("FAIL fs_last_cycle got %0d exp 0", last_rr); else passed++;
        total++; if (n_rf !== 0) $display("FAIL fs_fwd_leg got %0d exp 0", n_rf); else passed++;
    endtask

    task automatic test_reversal();
        measure(10, 12'hE0C, 12'h800, -1, 1'b1);
        total++; if (n_lf !== 500) $display("FAIL rev_pre_width got %0d exp 500", n_lf); else passed++;
        total++; if (n_lr !== 0) $display("FAIL rev_pre_revleg got %0d exp 0", n_lr); else passed++;
        measure(-1, 12'd0, 12'd0, -1, 1'b1);
        total++; if (n_lr !== 468) $display("FAIL rev_dead_width got %0d exp 468", n_lr); else passed++;
        total++; if (f_lr !== 32) $display("FAIL rev_dead_start got %0d exp 32", f_lr); else passed++;
        total++; if (n_lf !== 0) $display("FAIL rev_fwdleg got %0d exp 0", n_lf); else passed++;
        total++; if (ovl !== 0) $display("FAIL rev_overlap got %0d exp 0", ovl); else passed++;
        measure(10, 12'hED4, 12'd100, -1, 1'b1);
        total++; if (n_lr !== 500) $display("FAIL rev_next_width got %0d exp 500", n_lr); else passed++;
        total++; if (f_lr !== 0) $display("FAIL rev_next_start got %0d exp 0", f_lr); else passed++;
    endtask

    task automatic test_zero_hold();
        measure(10, 12'd0, 12'd100, -1, 1'b1);
        total++; if (n_lr !== 300) $display("FAIL hold_300_width got %0d exp 300", n_lr); else passed++;
        total++; if (f_lr !== 0) $display("FAIL hold_300_start got %0d exp 0", f_lr); else passed++;
        total++; if (n_rf !== 68) $display("FAIL r_rev_width got %0d exp 68", n_rf); else passed++;
        total++; if (f_rf !== 32) $display("FAIL r_rev_start got %0d exp 32", f_rf); else passed++;
        total++; if (n_rr !== 0) $display("FAIL r_rev_revleg got %0d exp 0", n_rr); else passed++;
        measure(10, 12'hED4, 12'd100, -1, 1'b1);
        total++; if (n_lf + n_lr !== 0) $display("FAIL zero_quiet got %0d exp 0", n_lf + n_lr); else passed++;
        total++; if (n_rf !== 100) $display("FAIL r_100_width got %0d exp 100", n_rf); else passed++;
        total++; if (f_rf !== 0) $display("FAIL r_100_start got %0d exp 0", f_rf); else passed++;
        measure(49, 12'd20, 12'd1500, -1, 1'b1);
        total++; if (n_lr !== 300) $display("FAIL after_zero_width got %0d exp 300", n_lr); else passed++;
        total++; if (f_lr !== 0) $display("FAIL after_zero_start got %0d exp 0", f_lr); else passed++;
        total++; if (n_rf !== 100) $display("FAIL mid_change_width got %0d exp 100", n_rf); else passed++;
    endtask

    task automatic test_enable();
        measure(-1, 12'd0, 12'd0, 699, 1'b0);
        total++; if (n_lf + n_lr !== 0) $display("FAIL small_rev_quiet got %0d exp 0", n_lf + n_lr); else passed++;
        total++; if (n_rf !== 700) $display("FAIL en_drop_width got %0d exp 700", n_rf); else passed++;
        total++; if (hi_after !== 0) $display("FAIL en_drop_quiet got %0d exp 0", hi_after); else passed++;
        bus.en = 1'b1;
        measure(10, 12'd1000, 12'd1500, -1, 1'b1);
        total++; if (n_lf !== 20) $display("FAIL chg_clear_width got %0d exp 20", n_lf); else passed++;
        total++; if (f_lf !== 0) $display("FAIL chg_clear_start got %0d exp 0", f_lf); else passed++;
        total++; if (n_rf !== 1500) $display("FAIL r_1500_width got %0d exp 1500", n_rf); else passed++;
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.prd_start !== 1'b1 && w < 2100);
        total++; if (bus.prd_start !== 1'b1) $display("FAIL mid_rst_wait got no prd_start exp pulse"); else passed++;
        repeat (399) @(negedge clk);
        total++; if (bus.lft_fwd !== 1'b1) $display("FAIL mid_rst_prepulse got %b exp 1", bus.lft_fwd); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({bus.lft_fwd, bus.lft_rev, bus.rght_fwd, bus.rght_rev, bus.prd_start} !== 5'b0)
            $display("FAIL mid_rst_async got %b exp 00000",
                     {bus.lft_fwd, bus.lft_rev, bus.rght_fwd, bus.rght_rev, bus.prd_start}); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure(-1, 12'd0, 12'd0, -1, 1'b1);
        total++; if (wait_n !== 1) $display("FAIL mid_rst_prd_delay got %0d exp 1", wait_n); else passed++;
        total++; if (n_lf + n_lr + n_rf + n_rr !== 0)
            $display("FAIL mid_rst_quiet got %0d exp 0", n_lf + n_lr + n_rf + n_rr); else passed++;
        measure(-1, 12'd0, 12'd0, -1, 1'b1);
        total++; if (n_lf !== 1000) $display("FAIL post_rst_lwidth got %0d exp 1000", n_lf); else passed++;
        total++; if (f_lf !== 0) $display("FAIL post_rst_lstart got %0d exp 0", f_lf); else passed++;
        total++; if (n_rf !== 1500) $display("FAIL post_rst_rwidth got %0d exp 1500", n_rf); else passed++;
        total++; if (n_rr !== 0) $display("FAIL post_rst_rrev got %0d exp 0", n_rr); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.lft_spd  = 12'd0;
        bus.rght_spd = 12'd0;
        test_reset();
        test_forward_fullscale();
        test_reversal();
        test_zero_hold();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
